mult_arb_ctrl: RTL
==================

MULT_ARB_CTRL -- requirements
Module: mult_arb_ctrl

Interface
REQ-001 Parameter RR, default 1, arbitration mode: 1 = round-robin, 0 = fixed priority to requester 0.
REQ-002 sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 has an operand pair pending.
REQ-005 req0_ready  output  1  requester 0 pair accepted this cycle (valid & ready).
REQ-006 req0_a, req0_b  input  16 each  requester 0 signed two's-complement operands.
REQ-007 req1_valid  input  1  requester 1 has an operand pair pending.
REQ-008 req1_ready  output  1  requester 1 pair accepted this cycle.
REQ-009 req1_a, req1_b  input  16 each  requester 1 signed operands.
REQ-010 res_valid  output  1  res_data/res_id hold a valid product.
REQ-011 res_ready  input  1  consumer accepts the result this cycle.
REQ-012 res_data  output  32  signed product a*b.
REQ-013 res_id  output  1  index of the requester that issued the product.

Function
REQ-014 The block SHALL share one internal instance of the team's combinational 16x16 signed radix-4 Booth / Wallace-tree multiplier core between both requesters.
REQ-015 Pipeline: stage S1 holds registered operands, id and s1_valid; the core is placed between S1 and S2; stage S2 holds the 32-bit product, id and s2_valid, and drives the res_* outputs directly.
REQ-016 advance = !s2_valid | res_ready; S1->S2 transfer and new acceptance occur only when advance=1.
REQ-017 Stall: when advance=0, S1 and S2 SHALL hold their contents, and both reqX_ready SHALL be 0.
REQ-018 At most one requester is granted per cycle; reqX_ready = grant_X & reqX_valid & advance; reqX_ready is never 1 while reqX_valid=0.
REQ-019 RR=1: with one valid requester, that requester is granted; with both valid, the requester other than last_grant is granted.
REQ-020 last_grant SHALL update only on an accepted transfer; holding, stalling and idle cycles leave it unchanged.
REQ-021 RR=0: requester 0 wins whenever req0_valid=1.
REQ-022 Latency: a pair accepted at edge N with no stall SHALL present res_valid=1 with its product from edge N+2; each stall cycle adds exactly one cycle.
REQ-023 Throughput: one product per cycle sustained while res_ready=1.
REQ-024 On an advance with no acceptance, s1_valid SHALL clear to 0; a bubble SHALL propagate to S2 as s2_valid=0.
REQ-025 res_data SHALL be the exact 32-bit two's-complement product, including -32768*-32768 = 0x40000000.
REQ-026 Ordering: results SHALL emerge in acceptance order; none is dropped or duplicated.
REQ-027 res_data/res_id SHALL remain stable while res_valid=1 and res_ready=0.
REQ-028 Requesters SHALL hold valid and operands stable until ready; the block is not required to tolerate retraction.

Reset
REQ-029 sys_rst_n=0 SHALL immediately clear s1_valid, s2_valid, res_valid, req0_ready and req1_ready to 0.
REQ-030 Reset SHALL set last_grant=1, so requester 0 wins the first contended cycle, and set res_data=0 and res_id=0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight products; after release, no stale result appears.
REQ-032 The first acceptance is possible at the first rising edge after sys_rst_n deasserts.

Verification
REQ-033 Single issue: req0 a=3, b=-4, res_ready=1 -> req0_ready high 1 cycle; 2 cycles later res_valid=1, res_data=0xFFFFFFF4, res_id=0.
REQ-034 Contention, RR=1: both valid continuously, res_ready=1 -> grants 0,1,0,1...; res_id sequence 0,1,0,1 with correct products.
REQ-035 Contention, RR=0: same stimulus -> only requester 0 granted; req1_ready stays 0.
REQ-036 Backpressure: res_ready=0 for 3 cycles with S1 and S2 full -> res_data held stable, both reqX_ready=0; on release, both products emerge in order with no loss.
REQ-037 Extremes: (-32768)*(-32768) -> 0x40000000; 32767*(-32768) -> 0xC0008000; 0*x -> 0.
REQ-038 Reset mid-flight: assert sys_rst_n=0 with S1 and S2 valid -> res_valid=0 immediately; after release with no requests, res_valid stays 0.

Source files
------------

// File: rtl/mult_arb_ctrl.sv
// mult_arb_ctrl: two requesters share one signed 16x16 multiplier behind a
// two-stage valid/ready pipeline (S1 operands, S2 product). Arbitration is
// round-robin (RR=1) or fixed priority to requester 0 (RR=0).

// Combinational signed multiplier core: radix-4 Booth recoding of op_b
// generates DATA_W/2 partial products, which a carry-save 3:2 tree folds
// into a sum/carry pair before one final carry-propagate add.
module mult_arb_booth_core #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0]   op_a,
  input  logic signed [DATA_W-1:0]   op_b,
  output logic signed [2*DATA_W-1:0] prod
);

  localparam int PW  = 2 * DATA_W;
  localparam int NPP = DATA_W / 2;

  // One Booth partial product: the 3-bit window selects 0, +-a or +-2a,
  // sign-extended to the full product width, then weighted by 4^digit.
  function automatic logic [PW-1:0] booth_pp(
    input logic signed [DATA_W-1:0] a,
    input logic [2:0]               sel,
    input int unsigned              shift
  );
    logic [PW-1:0] a_ext;
    logic [PW-1:0] pp;
    a_ext = {{DATA_W{a[DATA_W-1]}}, a};
    case (sel)
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = a_ext << 1;
      3'b100:         pp = ~(a_ext << 1) + PW'(1);
      3'b101, 3'b110: pp = ~a_ext + PW'(1);
      default:        pp = '0;
    endcase
    return pp << shift;
  endfunction

  logic [PW-1:0] sum_v;
  logic [PW-1:0] car_v;
  logic [PW-1:0] pp_v;
  logic [PW-1:0] csa_s;
  logic [PW-1:0] csa_c;

  // Partial-product generation and carry-save reduction. All arithmetic is
  // modulo 2^PW, which is exact because a signed DATA_W x DATA_W product
  // always fits in PW bits (including -2^(DATA_W-1) squared).
  always_comb begin
    sum_v = booth_pp(op_a, {op_b[1:0], 1'b0}, 0);
    car_v = booth_pp(op_a, op_b[3:1], 2);
    pp_v  = '0;
    csa_s = '0;
    csa_c = '0;
    for (int i = 2; i < NPP; i++) begin
      pp_v  = booth_pp(op_a, op_b[2*i+1 -: 3], 2 * i);
      csa_s = sum_v ^ car_v ^ pp_v;
      csa_c = ((sum_v & car_v) | (sum_v & pp_v) | (car_v & pp_v)) << 1;
      sum_v = csa_s;
      car_v = csa_c;
    end
    prod = sum_v + car_v;
  end

endmodule

module mult_arb_ctrl #(
  parameter bit RR     = 1'b1,
  parameter int DATA_W = 16
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic signed [DATA_W-1:0]   req0_a,
  input  logic signed [DATA_W-1:0]   req0_b,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic signed [DATA_W-1:0]   req1_a,
  input  logic signed [DATA_W-1:0]   req1_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic signed [2*DATA_W-1:0] res_data,
  output logic                       res_id
);

  // Arbitration and flow control
  logic adv;
  logic grant0;
  logic grant1;
  logic acc0;
  logic acc1;
  logic last_grant_q;
  logic last_grant_d;

  // Stage S1: registered operands
  logic                     vld_p1_q;
  logic                     vld_p1_d;
  logic                     id_p1_q;
  logic                     id_p1_d;
  logic signed [DATA_W-1:0] a_p1_q;
  logic signed [DATA_W-1:0] a_p1_d;
  logic signed [DATA_W-1:0] b_p1_q;
  logic signed [DATA_W-1:0] b_p1_d;

  // Stage S2: registered product
  logic                       vld_p2_q;
  logic                       vld_p2_d;
  logic                       id_p2_q;
  logic                       id_p2_d;
  logic signed [2*DATA_W-1:0] prod_p2_q;
  logic signed [2*DATA_W-1:0] prod_p2_d;

  logic signed [2*DATA_W-1:0] core_prod;

  // Grant selection and handshake. The whole pipe moves as one unit, so a
  // full S2 that is not being drained freezes both stages and all inputs.
  // Ready is also masked by reset so nothing is acknowledged while held.
  always_comb begin
    adv = !vld_p2_q || res_ready;
    if (RR) begin
      grant0 = req0_valid && (!req1_valid || last_grant_q);
    end else begin
      grant0 = req0_valid;
    end
    grant1 = req1_valid && !grant0;
    acc0   = grant0 && req0_valid && adv && sys_rst_n;
    acc1   = grant1 && req1_valid && adv && sys_rst_n;

    last_grant_d = last_grant_q;
    if (acc0) begin
      last_grant_d = 1'b0;
    end else if (acc1) begin
      last_grant_d = 1'b1;
    end
  end

  // S1 next state: load the accepted pair, or insert a bubble on an advance
  // with no acceptance; hold everything while stalled.
  always_comb begin
    vld_p1_d = vld_p1_q;
    id_p1_d  = id_p1_q;
    a_p1_d   = a_p1_q;
    b_p1_d   = b_p1_q;
    if (adv) begin
      vld_p1_d = acc0 || acc1;
      if (acc0) begin
        id_p1_d = 1'b0;
        a_p1_d  = req0_a;
        b_p1_d  = req0_b;
      end else if (acc1) begin
        id_p1_d = 1'b1;
        a_p1_d  = req1_a;
        b_p1_d  = req1_b;
      end
    end
  end

  // ---- S1 -> S2 boundary: shared multiplier core ----
  mult_arb_booth_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .op_a (a_p1_q),
    .op_b (b_p1_q),
    .prod (core_prod)
  );

  // S2 next state: capture the product only when S1 carries a real pair so
  // a bubble leaves the last product parked on res_data.
  always_comb begin
    vld_p2_d  = vld_p2_q;
    id_p2_d   = id_p2_q;
    prod_p2_d = prod_p2_q;
    if (adv) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        id_p2_d   = id_p1_q;
        prod_p2_d = core_prod;
      end
    end
  end

  // Control state: valids and round-robin pointer, cleared asynchronously.
  // last_grant resets to 1 so requester 0 wins the first contended cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
      last_grant_q <= last_grant_d;
    end
  end

  // S1 operand registers carry no reset; they are qualified by vld_p1_q.
  always_ff @(posedge sys_clk) begin
    id_p1_q <= id_p1_d;
    a_p1_q  <= a_p1_d;
    b_p1_q  <= b_p1_d;
  end

  // S2 result registers drive the outputs and read as zero out of reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      id_p2_q   <= 1'b0;
      prod_p2_q <= '0;
    end else begin
      id_p2_q   <= id_p2_d;
      prod_p2_q <= prod_p2_d;
    end
  end

  assign req0_ready = acc0;
  assign req1_ready = acc1;
  assign res_valid  = vld_p2_q;
  assign res_data   = prod_p2_q;
  assign res_id     = id_p2_q;

endmodule
